// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-ported, fixed-latency unified memory between the
//   instruction-fetch path and the data (load/store) path. One requester is
//   granted at a time. The memory port is held stable for LATENCY cycles.
//   Completion is signalled by a one-cycle ready pulse. Combinational stall
//   outputs let the pipeline freeze while a request is outstanding.
//
//   Timing, with the request first sampled at edge 0:
//     cycles 1..LATENCY : mem_enable = 1, port driven from latched registers
//     cycle  LATENCY+1  : ready = 1 (an IDLE cycle; a held req is re-granted
//                         at the end of this cycle)
//
// Parameters:
//   LATENCY : cycles the memory needs a request held stable (1..15)
//   ADDR_W  : address width
//   DATA_W  : data width
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   if_req/if_addr      : fetch request and address (held until if_ready)
//   if_data/if_ready    : fetched instruction and completion pulse
//   if_stall            : if_req & ~if_ready
//   d_req/d_wr/d_addr   : data request, 1 = store, address
//   d_wdata             : store data
//   d_rdata/d_ready     : load data and completion pulse (stores pulse too)
//   d_stall             : d_req & ~d_ready
//   mem_enable/mem_wr   : memory enable (whole access) and write strobe
//   mem_addr            : memory address
//   mem_data_in         : write data towards memory
//   mem_data_out        : read data from memory
//
// Configuration:
//   ARB_RR_EN : when defined, contention in IDLE is resolved round-robin using
//               a 1-bit last-grant register (reset value = fetch). When not
//               defined, data always wins, so a continuous d_req starves fetch.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_ready,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,

    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // Four bits cover the legal LATENCY range; the counter runs LATENCY-1..0.
    localparam int            CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic grant_d;
    logic grant_i;

`ifdef ARB_RR_EN
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    grant_t last_grant;
`endif

    // Stalls are combinational so the PC freezes in the same cycle the
    // request appears, and release exactly in the ready cycle.
    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req  & ~d_ready;

    // Grant decision, only acted upon while IDLE.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_d = 1'b0;
        grant_i = 1'b0;
`ifdef ARB_RR_EN
        // On contention serve whoever was not served last; a lone request
        // is always granted.
        if (d_req && if_req) begin
            grant_d = (last_grant == GRANT_I);
            grant_i = (last_grant == GRANT_D);
        end else begin
            grant_d = d_req;
            grant_i = if_req;
        end
`else
        // Fixed data priority: the older instruction in the pipeline
        // (the one doing the load/store) completes first.
        grant_d = d_req;
        grant_i = if_req & ~d_req;
`endif
    end

    // Single FSM with registered outputs. The mem_* registers double as the
    // latched request, so requester input changes mid-access are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset drops any access in flight: mem_enable falls immediately
            // and no ready pulse follows.
            state       <= IDLE;
            cnt         <= '0;
            if_data     <= '0;
            if_ready    <= 1'b0;
            d_rdata     <= '0;
            d_ready     <= 1'b0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
`ifdef ARB_RR_EN
            last_grant  <= GRANT_I;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of statement
            // order.
            // Ready pulses last exactly one cycle unless re-asserted below.
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= BUSY_D;
                        cnt         <= CNT_INIT;
                        mem_enable  <= 1'b1;
                        mem_wr      <= d_wr;
                        mem_addr    <= d_addr;
                        mem_data_in <= d_wdata;
`ifdef ARB_RR_EN
                        last_grant  <= GRANT_D;
`endif
                    end else if (grant_i) begin
                        state       <= BUSY_I;
                        cnt         <= CNT_INIT;
                        mem_enable  <= 1'b1;
                        mem_wr      <= 1'b0;
                        mem_addr    <= if_addr;
                        mem_data_in <= '0;
`ifdef ARB_RR_EN
                        last_grant  <= GRANT_I;
`endif
                    end
                end

                BUSY_I: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        mem_enable <= 1'b0;
                        mem_wr     <= 1'b0;
                        if_data    <= mem_data_out;
                        if_ready   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                BUSY_D: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        mem_enable <= 1'b0;
                        mem_wr     <= 1'b0;
                        // A store still pulses d_ready but leaves d_rdata alone.
                        if (!mem_wr) begin
                            d_rdata <= mem_data_out;
                        end
                        d_ready    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                end
            endcase
        end
    end

endmodule
